hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameter MUL_LAT, default 3, giving the multiply result latency in cycles (legal range 1..7).
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n; these are listed first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 id_valid  input  1  an instruction is present in the ID stage.
REQ-006 id_rs, id_rt  input  4 each  ID source register ids.
REQ-007 id_rs_used, id_rt_used  input  1 each  the corresponding source is actually read.
REQ-008 id_rd  input  4  ID destination register id.
REQ-009 id_rw  input  1  the ID instruction writes id_rd.
REQ-010 id_mr  input  1  the ID instruction is a load.
REQ-011 id_mul  input  1  the ID instruction is a multi-cycle multiply.
REQ-012 wb_rw, wb_rd  input  1, 4  a register write is retiring in WB.
REQ-013 br_taken  input  1  a branch resolved taken in EX.
REQ-014 stall  output  1  hold the PC and the IF/ID register.
REQ-015 bubble_idex  output  1  insert a NOP into ID/EX.
REQ-016 flush_ifid, flush_idex  output  1 each  squash the IF/ID and ID/EX contents.
REQ-017 busy_mask  output  16  registers with an in-flight write (bit 0 always 0).
REQ-018 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-019 SHALL treat register 0 as never pending, never a hazard source and never a hazard target.
REQ-020 SHALL define "accept" = id_valid & ~stall & ~br_taken, evaluated in the same cycle.
REQ-021 On accept with id_rw=1 and id_rd!=0, SHALL set busy_mask[id_rd] at the next edge.
REQ-022 When wb_rw=1 and wb_rd!=0, SHALL clear busy_mask[wb_rd] at the next edge.
REQ-023 If a set and a clear of the same bit occur in one cycle, the set SHALL win.
REQ-024 Load tracking: on accept of a load with rd!=0, SHALL register ld_valid=1 and ld_rd=id_rd; in any other cycle ld_valid SHALL clear to 0 at the next edge.
REQ-025 Load-use hazard = id_valid & ld_valid & ((id_rs_used & id_rs==ld_rd) | (id_rt_used & id_rt==ld_rd)); this SHALL give exactly one stall cycle.
REQ-026 Multiply tracking: on accept of a multiply, SHALL load the 3-bit mul_cnt with MUL_LAT and mul_rd with id_rd; mul_cnt SHALL decrement by 1 per cycle while nonzero.
REQ-027 Multiply hazard = id_valid & mul_cnt!=0 & one of:
 - a used source equals mul_rd (mul_rd!=0);
 - id_rw=1 and id_rd==mul_rd (WAW);
 - id_mul=1 (structural).
REQ-028 stall SHALL be combinational: (load-use hazard | multiply hazard) & ~br_taken.
REQ-029 bubble_idex SHALL equal stall.
REQ-030 flush_ifid and flush_idex SHALL equal br_taken.
REQ-031 br_taken SHALL override stall, and the squashed ID instruction SHALL NOT update any state.
REQ-032 mul_cnt SHALL keep counting through flushes.
REQ-033 Forwardable ALU results SHALL NOT cause a stall; resolving them is the forwarding unit's job.
REQ-034 stall_cnt SHALL increment on each cycle with stall=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-035 While rst_n=0, the following SHALL be 0 asynchronously: busy_mask, ld_valid, ld_rd, mul_cnt, mul_rd and stall_cnt.
REQ-036 During reset, stall and bubble_idex SHALL read 0; flush outputs SHALL follow br_taken.
REQ-037 On reset deassertion, the first rising edge SHALL accept normally.
REQ-038 Reset asserted mid-multiply SHALL abandon the countdown with no residual stall.

Verification
REQ-039 Load-use: accept a load with rd=5 at cycle T; at T+1 present id_rs=5 with id_rs_used=1.
 - Required: stall=bubble=1 at T+1 only; stall=0 at T+2; stall_cnt=1.
REQ-040 Multiply with MUL_LAT=3: accept a mul with rd=7 at T; the consumer of r7 sits in ID from T+1.
 - Required: stall=1 at T+1, T+2 and T+3; stall=0 at T+4.
 - A second mul at T+1 SHALL also stall until T+4.
REQ-041 Register 0: a load with rd=0, then a consumer of r0.
 - Required: stall never asserts; busy_mask stays 16'h0000.
REQ-042 Flush priority: a load-use hazard and br_taken=1 in the same cycle.
 - Required: stall=0, flush_ifid=flush_idex=1; busy_mask and ld_valid unchanged by the squashed instruction.
REQ-043 Set/clear collision: WB retires r3 while a new writer of r3 is accepted in the same cycle.
 - Required: busy_mask[3]=1 afterward.
REQ-044 Reset mid-multiply: assert rst_n=0 with mul_cnt=2.
 - Required: outputs cleared immediately; the r7 consumer after release proceeds with stall=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Interlock and scoreboard unit for a five-stage in-order pipeline with a
// multi-cycle multiplier. It tracks which architectural registers have a
// write in flight. It detects load-use hazards and multiply hazards: RAW,
// WAW and structural. It issues stall, bubble and flush controls to the
// front end.
//
// Parameters
//   MUL_LAT      multiply result latency in cycles (1..7)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   id_valid     an instruction occupies ID
//   id_rs/id_rt  ID source register ids
//   id_rs_used   id_rs is actually read
//   id_rt_used   id_rt is actually read
//   id_rd        ID destination register id
//   id_rw        ID instruction writes id_rd
//   id_mr        ID instruction is a load
//   id_mul       ID instruction is a multi-cycle multiply
//   wb_rw/wb_rd  register write retiring in WB
//   br_taken     branch resolved taken in EX
//   stall        hold PC and IF/ID
//   bubble_idex  insert a NOP into ID/EX
//   flush_ifid   squash IF/ID
//   flush_idex   squash ID/EX
//   busy_mask    registers with an in-flight write (bit 0 always 0)
//   stall_cnt    saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [3:0]  id_rd,
    input  logic        id_rw,
    input  logic        id_mr,
    input  logic        id_mul,
    input  logic        wb_rw,
    input  logic [3:0]  wb_rd,
    input  logic        br_taken,
    output logic        stall,
    output logic        bubble_idex,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [15:0] busy_mask,
    output logic [15:0] stall_cnt
);

    localparam logic [2:0] MUL_LAT_C = 3'(MUL_LAT);

    // Tracking state
    logic        ld_valid;
    logic [3:0]  ld_rd;
    logic [2:0]  mul_cnt;
    logic [3:0]  mul_rd;
    logic [15:0] busy_q;
    logic [15:0] stall_cnt_q;

    // Combinational decode
    logic        load_use;
    logic        mul_hz;
    logic        stall_int;
    logic        accept;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] busy_next;

    // Saturating increment for the stall counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // A used, non-zero source that matches a tracked destination.
    // Register 0 never matches, so r0 can never be a hazard source.
    function automatic logic src_hit(input logic       used,
                                     input logic [3:0] src,
                                     input logic [3:0] tgt);
        return used && (src != 4'd0) && (src == tgt);
    endfunction

    always_comb begin
        load_use  = 1'b0;
        mul_hz    = 1'b0;
        stall_int = 1'b0;
        accept    = 1'b0;
        set_vec   = '0;
        clr_vec   = '0;
        busy_next = '0;

        // ld_valid is only ever set for a non-zero destination.
        load_use = id_valid && ld_valid &&
                   (src_hit(id_rs_used, id_rs, ld_rd) ||
                    src_hit(id_rt_used, id_rt, ld_rd));

        // While the multiplier counts down, block consumers and writers
        // of its destination. Also block any second multiply, because
        // the unit is not pipelined.
        mul_hz = id_valid && (mul_cnt != 3'd0) &&
                 (((mul_rd != 4'd0) &&
                   (src_hit(id_rs_used, id_rs, mul_rd) ||
                    src_hit(id_rt_used, id_rt, mul_rd))) ||
                  (id_rw && (id_rd != 4'd0) && (id_rd == mul_rd)) ||
                  id_mul);

        // A taken branch squashes ID, so it overrides any interlock.
        stall_int = (load_use || mul_hz) && !br_taken;
        accept    = id_valid && !stall_int && !br_taken;

        if (accept && id_rw && (id_rd != 4'd0)) begin
            set_vec[id_rd] = 1'b1;
        end
        if (wb_rw && (wb_rd != 4'd0)) begin
            clr_vec[wb_rd] = 1'b1;
        end

        // Apply the set after the clear, so a new writer wins over a
        // retiring write to the same register.
        busy_next = ((busy_q & ~clr_vec) | set_vec) & 16'hFFFE;
    end

    // ---- register stage: scoreboard and hazard trackers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            ld_valid <= 1'b0;
            ld_rd    <= '0;
        end else begin
            busy_q <= busy_next;
            // A load shadow lasts exactly one cycle after acceptance.
            if (accept && id_mr && (id_rd != 4'd0)) begin
                ld_valid <= 1'b1;
                ld_rd    <= id_rd;
            end else begin
                ld_valid <= 1'b0;
            end
        end
    end

    // The countdown ignores flushes. The multiply is already in flight
    // and still occupies the unit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_cnt <= '0;
            mul_rd  <= '0;
        end else if (accept && id_mul) begin
            mul_cnt <= MUL_LAT_C;
            mul_rd  <= id_rd;
        end else if (mul_cnt != 3'd0) begin
            mul_cnt <= mul_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall_int) begin
            stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    // ---- output stage ----
    // The trackers clear asynchronously, so stall already reads 0 during
    // reset. The flush outputs are pure functions of br_taken.
    assign stall       = stall_int;
    assign bubble_idex = stall_int;
    assign flush_ifid  = br_taken;
    assign flush_idex  = br_taken;
    assign busy_mask   = busy_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic [3:0]  id_rd;
    logic        id_rw;
    logic        id_mr;
    logic        id_mul;
    logic        wb_rw;
    logic [3:0]  wb_rd;
    logic        br_taken;
    logic        stall;
    logic        bubble_idex;
    logic        flush_ifid;
    logic        flush_idex;
    logic [15:0] busy_mask;
    logic [15:0] stall_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    hazard_scoreboard #(.MUL_LAT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_used  (id_rs_used),
        .id_rt_used  (id_rt_used),
        .id_rd       (id_rd),
        .id_rw       (id_rw),
        .id_mr       (id_mr),
        .id_mul      (id_mul),
        .wb_rw       (wb_rw),
        .wb_rd       (wb_rd),
        .br_taken    (br_taken),
        .stall       (stall),
        .bubble_idex (bubble_idex),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .busy_mask   (busy_mask),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [3:0] rs, input logic rsu,
                            input logic [3:0] rt, input logic rtu, input logic [3:0] rd,
                            input logic rw, input logic mr, input logic mul);
        id_valid   = v;
        id_rs      = rs;
        id_rs_used = rsu;
        id_rt      = rt;
        id_rt_used = rtu;
        id_rd      = rd;
        id_rw      = rw;
        id_mr      = mr;
        id_mul     = mul;
        #1;
    endtask

    task automatic idle();
        drive_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_rw    = 1'b0;
        wb_rd    = 4'd0;
        br_taken = 1'b1;
        idle();

        // Reset state: flushes follow br_taken, everything else is zero
        #1;
        check("rst_flush_ifid", 32'(flush_ifid), 32'd1);
        check("rst_flush_idex", 32'(flush_idex), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_busy", 32'(busy_mask), 32'h0000);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        br_taken = 1'b0;
        #1;
        check("rst_flush_off", 32'(flush_ifid), 32'd0);
        step();
        rst_n = 1'b1;

        // Load-use: load r5 at T, consumer of r5 at T+1
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        check("ld_T_stall", 32'(stall), 32'd0);
        step();
        check("ld_busy", 32'(busy_mask), 32'h0020);
        drive_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("ld_T1_stall", 32'(stall), 32'd1);
        check("ld_T1_bubble", 32'(bubble_idex), 32'd1);
        step();
        check("ld_T2_stall", 32'(stall), 32'd0);
        check("ld_stall_cnt", 32'(stall_cnt), 32'd1);
        step();
        idle();
        wb_rw = 1'b1;
        wb_rd = 4'd5;
        step();
        wb_rw = 1'b0;
        check("ld_wb_clear", 32'(busy_mask), 32'h0000);

        // Multiply RAW: mul r7 at T, consumer from T+1
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
        check("mul_T_stall", 32'(stall), 32'd0);
        step();
        drive_id(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check("mul_busy", 32'(busy_mask), 32'h0080);
        check("mul_T1_stall", 32'(stall), 32'd1);
        step();
        check("mul_T2_stall", 32'(stall), 32'd1);
        step();
        check("mul_T3_stall", 32'(stall), 32'd1);
        step();
        check("mul_T4_stall", 32'(stall), 32'd0);
        check("mul_stall_cnt", 32'(stall_cnt), 32'd4);
        step();
        idle();
        wb_rw = 1'b1;
        wb_rd = 4'd7;
        step();
        wb_rw = 1'b0;

        // Structural: mul r9 at T, second mul r10 at T+1
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b1);
        check("mul2_T_stall", 32'(stall), 32'd0);
        step();
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b1);
        check("mul2_T1_stall", 32'(stall), 32'd1);
        step();
        check("mul2_T2_stall", 32'(stall), 32'd1);
        step();
        check("mul2_T3_stall", 32'(stall), 32'd1);
        step();
        check("mul2_T4_stall", 32'(stall), 32'd0);
        step();
        // WAW: an ALU writer of r10 while the second mul is in flight
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0);
        check("mul2_busy", 32'(busy_mask), 32'h0600);
        check("waw_stall", 32'(stall), 32'd1);
        step();
        idle();
        step();
        step();
        step();
        check("waw_stall_cnt", 32'(stall_cnt), 32'd8);
        wb_rw = 1'b1;
        wb_rd = 4'd9;
        step();
        wb_rd = 4'd10;
        step();
        wb_rw = 1'b0;
        check("mul2_wb_clear", 32'(busy_mask), 32'h0000);

        // Register 0: load r0, then consumer of r0
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        check("r0_ld_stall", 32'(stall), 32'd0);
        step();
        check("r0_busy", 32'(busy_mask), 32'h0000);
        drive_id(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check("r0_use_stall", 32'(stall), 32'd0);
        step();
        check("r0_busy2", 32'(busy_mask), 32'h0000);

        // Flush priority: load-use hazard plus br_taken in one cycle
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        step();
        drive_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0);
        br_taken = 1'b1;
        #1;
        check("fl_stall", 32'(stall), 32'd0);
        check("fl_bubble", 32'(bubble_idex), 32'd0);
        check("fl_ifid", 32'(flush_ifid), 32'd1);
        check("fl_idex", 32'(flush_idex), 32'd1);
        step();
        br_taken = 1'b0;
        check("fl_busy", 32'(busy_mask), 32'h0020);
        drive_id(1'b1, 4'd6, 1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        check("fl_no_ld", 32'(stall), 32'd0);
        check("fl_stall_cnt", 32'(stall_cnt), 32'd8);
        step();
        idle();
        wb_rw = 1'b1;
        wb_rd = 4'd5;
        step();
        wb_rw = 1'b0;

        // Set/clear collision on r3
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
        step();
        check("col_set", 32'(busy_mask), 32'h0008);
        wb_rw = 1'b1;
        wb_rd = 4'd3;
        step();
        check("col_set_wins", 32'(busy_mask), 32'h0008);
        idle();
        step();
        wb_rw = 1'b0;
        check("col_clear", 32'(busy_mask), 32'h0000);

        // Reset mid-multiply with mul_cnt=2
        drive_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        step();
        drive_id(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0);
        check("rm_pre_stall", 32'(stall), 32'd1);
        check("rm_pre_busy", 32'(busy_mask), 32'h0080);
        rst_n = 1'b0;
        #1;
        check("rm_stall", 32'(stall), 32'd0);
        check("rm_bubble", 32'(bubble_idex), 32'd0);
        check("rm_busy", 32'(busy_mask), 32'h0000);
        check("rm_stall_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("rm_rel_stall", 32'(stall), 32'd0);
        step();
        check("rm_first_accept", 32'(busy_mask), 32'h0004);
        check("rm_cnt_after", 32'(stall_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
